// File: rtl/axi_stream_unpacker.sv
// Width down-converter: one IN_WIDTH word out as RATIO OUT_WIDTH beats, LSB slice first, last on final beat.
// Latency: first beat valid the cycle after the word is accepted; one EMPTY bubble per word unless UNPACK_SKID_EN.
// Backpressure: beats hold while rdy_out=0; rdy_in only when idle (UNPACK_SKID_EN also on the final accepted beat).
module axi_stream_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_in,
    output logic                 rdy_in,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 last_in,
    output logic                 vld_out,
    input  logic                 rdy_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 last_out
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_param_err
            $error("axi_stream_unpacker: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  word_q;
    logic                 last_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 load;
    logic                 in_xfer, out_xfer, cnt_is_last;
    logic [OUT_WIDTH-1:0] slice [RATIO];

    genvar g;
    generate
        for (g = 0; g < RATIO; g++) begin : g_slice
            assign slice[g] = word_q[g*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    assign cnt_is_last = (cnt_q == CNT_LAST);
    assign vld_out     = (state_q == BUSY);
    assign data_out    = slice[cnt_q];
    assign last_out    = vld_out && last_q && cnt_is_last;

`ifdef UNPACK_SKID_EN
    // Refill on the same edge the final beat leaves: combinational rdy_out -> rdy_in.
    assign rdy_in = !rst && ((state_q == EMPTY) || (state_q == BUSY && cnt_is_last && rdy_out));
`else
    assign rdy_in = !rst && (state_q == EMPTY);
`endif

    assign in_xfer  = vld_in && rdy_in;
    assign out_xfer = vld_out && rdy_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                if (out_xfer) begin
                    if (cnt_is_last) begin
                        cnt_d = '0;
                        if (in_xfer) begin
                            load = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                word_q <= data_in;
                last_q <= last_in;
            end
        end
    end

endmodule

// File: doc/axi_stream_unpacker.md
Name: axi_stream_unpacker

Overview:
- Valid/ready stream width down-converter. Accepts one IN_WIDTH word (e.g. from axi_fifo output) and emits it as RATIO = IN_WIDTH/OUT_WIDTH narrow beats, LSB slice first.
- Sits between wide-word producers (FIFOs, raster setup) and narrow consumers (pixel/fragment streams, memory write ports).
- Propagates a packet-end flag onto the final narrow beat.

Parameters:
- IN_WIDTH, 64, width of input word.
- OUT_WIDTH, 16, width of output beat. IN_WIDTH % OUT_WIDTH must be 0 and RATIO must be >= 2. Otherwise $error at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- vld_in  input  1  upstream word valid.
- rdy_in  output  1  unpacker can accept a word.
- data_in  input  IN_WIDTH  upstream word.
- last_in  input  1  word is the final word of a packet.
- vld_out  output  1  downstream beat valid.
- rdy_out  input  1  downstream accepts beat.
- data_out  output  OUT_WIDTH  current beat.
- last_out  output  1  final beat of a packet.

Behaviour:
- Interface is fixed: one clock, clk; reset rst is asynchronous and active-high.
- State:
  - word_q[IN_WIDTH-1:0]: held word.
  - last_q: latched last_in.
  - cnt[$clog2(RATIO)-1:0]: beat index.
  - FSM with two states, EMPTY and BUSY.
- Reset (async assert, sync release):
  - state=EMPTY, cnt=0, word_q=0, last_q=0.
  - Outputs: vld_out=0, data_out=0, last_out=0.
  - rdy_in is forced 0 while rst=1.
- Input transfer occurs when vld_in && rdy_in at a clk edge.
- Output transfer occurs when vld_out && rdy_out at a clk edge.
- EMPTY state:
  - rdy_in=1, vld_out=0.
  - On input transfer: word_q<=data_in, last_q<=last_in, cnt<=0, go to BUSY.
- BUSY state:
  - vld_out=1.
  - data_out = word_q[cnt*OUT_WIDTH +: OUT_WIDTH].
  - last_out = last_q && (cnt==RATIO-1).
  - On output transfer with cnt<RATIO-1: cnt<=cnt+1.
  - On output transfer with cnt==RATIO-1: go to EMPTY, cnt<=0.
- Latency: word accepted at edge N → first beat valid in the cycle after edge N.
- Outputs are driven from registers (no data_in→data_out combinational path).
- Backpressure: while vld_out=1 && rdy_out=0, data_out, last_out and cnt are held stable. vld_out never drops without a transfer, except on reset.
- data_out outside BUSY equals slice cnt of word_q and is not checked. After reset it is 0.
- last_in is sampled only on input transfer. last_out is never asserted on beats 0..RATIO-2.
- Throughput without the optional feature: RATIO beats per RATIO+1 cycles (one EMPTY bubble per word).
- Reset mid-word: vld_out drops immediately (asynchronous). Remaining beats are discarded. After release, rdy_in=1.

Optional Feature:
- Macro: UNPACK_SKID_EN.
- Defined:
  - rdy_in = (state==EMPTY) || (state==BUSY && cnt==RATIO-1 && rdy_out).
  - A new word can be accepted on the same edge the final beat transfers. The FSM stays in BUSY with cnt<=0 and word_q/last_q reloaded, giving zero bubbles.
  - This permits a combinational rdy_out→rdy_in path.
- Undefined: rdy_in = (state==EMPTY) only. There is no combinational path from rdy_out.

Test Plan:
- Reset: hold rst=1 with vld_in=1 → rdy_in=0, vld_out=0, data_out=0, last_out=0. After release, rdy_in=1 and no beat is emitted.
- Single word: data_in=64'h4444_3333_2222_1111, last_in=1, rdy_out=1 always → beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 on 4 consecutive cycles starting the cycle after accept. last_out=1 only on 16'h4444.
- Backpressure: same word with rdy_out=0 for 3 cycles while data_out=16'h2222 → vld_out stays 1 and data_out holds 16'h2222. Sequence resumes with 16'h3333 and no beat is lost or duplicated.
- Back-to-back words (A=64'h0004_0003_0002_0001, last_in=0; B=64'h0008_0007_0006_0005, last_in=1), vld_in=1, rdy_out=1, A accepted at edge 0:
  - Without UNPACK_SKID_EN: beats 1..4 in cycles 1-4, bubble in cycle 5, beats 5..8 in cycles 6-9.
  - With UNPACK_SKID_EN: beats 1..8 in cycles 1-8 with no bubble.
  - In both cases last_out=1 only on beat 0x0008.
- Busy-blocking (macro undefined): present a new vld_in=1 word while cnt=1 → rdy_in=0 and the word is not captured until after the fourth beat transfers.
- Reset mid-word: assert rst asynchronously after beat 16'h1111 transfers → vld_out=0 before the next edge. After release, new word 64'hDDDD_CCCC_BBBB_AAAA emits 16'hAAAA first.
